// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB memory slave.
package apb_mem_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  // Wait counter width; WAIT_CYCLES is limited to 0..15.
  localparam int WAIT_W     = 4;

  // Unsigned compare over the full address, no wrap modulo depth.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage: synchronous write on we, combinational read of raddr.
// Write lands at the edge where we is high; no backpressure.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    if (we) memory[waddr] <= wdata;
  end

  assign rdata = memory[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave over a word array; each transfer takes 2+WAIT_CYCLES cycles with PReady in the last.
// Out-of-range addresses complete with PSlvErr and never touch the array.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic [DATA_W-1:0] PWData,
  input  logic              PWrite,
  input  logic              PSel,
  input  logic              PEnable,
  output logic [DATA_W-1:0] PRData,
  output logic              PReady,
  output logic              PSlvErr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              write;

  logic              capture, access, done, ready_next;
  logic              cur_write, cur_ok, mem_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] rdata;

  // SETUP state also covers the first access cycle (counter 0).
  assign capture   = PSel && !PEnable && (state == IDLE || state == SETUP);
  assign access    = PSel && PEnable && (state != IDLE);
  assign done      = access && (cnt == WAIT_LAST);
  assign cur_addr  = capture ? PAddr : addr;
  assign cur_write = capture ? PWrite : write;
  assign cur_ok    = in_range(32'(cur_addr), DEPTH);
  assign mem_we    = done && write && cur_ok;

  // Outputs are registered, so PReady is raised one edge ahead of the cycle it belongs to.
  assign ready_next = (capture && (WAIT_LAST == '0)) ||
                      (access && !done && ((cnt + 1'b1) == WAIT_LAST));

  apb_mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(addr[IDX_W-1:0]),
    .wdata(wdata),
    .raddr(cur_addr[IDX_W-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr    <= '0;
      wdata   <= '0;
      write   <= 1'b0;
      PReady  <= 1'b0;
      PSlvErr <= 1'b0;
      PRData  <= '0;
    end else begin
      PReady  <= ready_next;
      PSlvErr <= ready_next && !cur_ok;
      PRData  <= (ready_next && !cur_write && cur_ok) ? rdata : '0;
      case (state)
        IDLE: begin
          if (capture) begin
            addr  <= PAddr;
            wdata <= PWData;
            write <= PWrite;
            cnt   <= '0;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (!PSel) begin
            state <= IDLE;
          end else if (!PEnable) begin
            addr  <= PAddr;
            wdata <= PWData;
            write <= PWrite;
          end else if (done) begin
            state <= IDLE;
          end else begin
            state <= ACCESS;
            cnt   <= cnt + 1'b1;
          end
        end
        ACCESS: begin
          if (access && !done) begin
            cnt <= cnt + 1'b1;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (0 and 2 wait states) against a transfer-level model.
module tb_apb_mem_slave;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        Rst;
  logic [15:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic        pwrite  [2];
  logic        psel    [2];
  logic        penable [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  int checks   = 0;
  int failures = 0;

  // Model state: array contents plus the transfer captured in the setup cycle.
  logic [31:0] model_mem [2][DEPTH];
  logic [15:0] lat_addr  [2];
  logic [31:0] lat_data  [2];
  logic        lat_wr    [2];
  logic        in_xfer   [2];
  int          acc_n     [2];

  always #5 clk = ~clk;

  apb_mem_slave #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .Rst(Rst), .PAddr(paddr[0]), .PWData(pwdata[0]), .PWrite(pwrite[0]),
    .PSel(psel[0]), .PEnable(penable[0]), .PRData(prdata[0]), .PReady(pready[0]),
    .PSlvErr(pslverr[0]));

  apb_mem_slave #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .Rst(Rst), .PAddr(paddr[1]), .PWData(pwdata[1]), .PWrite(pwrite[1]),
    .PSel(psel[1]), .PEnable(penable[1]), .PRData(prdata[1]), .PReady(pready[1]),
    .PSlvErr(pslverr[1]));

  function automatic int wc(input int u);
    return (u == 0) ? 0 : 2;
  endfunction

  function automatic logic [31:0] peek(input int u, input int i);
    if (u == 0) return dut0.mem.memory[i];
    return dut2.mem.memory[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic mem_scan(input int u, input string name);
    int bad = 0;
    int first = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (peek(u, i) !== model_mem[u][i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d words differ, first idx %0d got %h want %h",
               name, bad, first, peek(u, first), model_mem[u][first]);
    end
  endtask

  // Per-cycle output check: PReady only in access cycle index WAIT_CYCLES, everything else zero.
  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        logic        ey, er;
        logic [31:0] ed;
        ey = 1'b0;
        er = 1'b0;
        ed = '0;
        if (!Rst) begin
          in_xfer[u] = 1'b0;
        end else if (psel[u] && !penable[u]) begin
          lat_addr[u] = paddr[u];
          lat_data[u] = pwdata[u];
          lat_wr[u]   = pwrite[u];
          in_xfer[u]  = 1'b1;
          acc_n[u]    = 0;
        end else if (psel[u] && penable[u] && in_xfer[u]) begin
          if (acc_n[u] == wc(u)) begin
            ey = 1'b1;
            er = (lat_addr[u] >= DEPTH);
            if (!lat_wr[u] && !er) ed = model_mem[u][lat_addr[u]];
            if (lat_wr[u] && !er) model_mem[u][lat_addr[u]] = lat_data[u];
            in_xfer[u] = 1'b0;
          end else begin
            acc_n[u]++;
          end
        end else begin
          in_xfer[u] = 1'b0;
        end
        checks++;
        if ({pready[u], pslverr[u], prdata[u]} !== {ey, er, ed}) begin
          failures++;
          $display("FAIL cycle_out u%0d t=%0t: rdy/err/rdata got %b/%b/%h want %b/%b/%h",
                   u, $time, pready[u], pslverr[u], prdata[u], ey, er, ed);
        end
      end
    end
  end

  task automatic xfer(input int u, input logic wr, input logic [15:0] a, input logic [31:0] d,
                      input bit scramble, output logic [31:0] rd, output logic err, output int cyc);
    bit fin = 1'b0;
    @(posedge clk); #1;
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = a; pwdata[u] = d;
    @(posedge clk); #1;
    penable[u] = 1'b1;
    cyc = 2;
    rd = '0;
    err = 1'b0;
    if (scramble) begin paddr[u] = 16'($urandom); pwdata[u] = $urandom; end
    while (!fin) begin
      @(negedge clk);
      if (pready[u]) begin
        rd = prdata[u];
        err = pslverr[u];
        fin = 1'b1;
      end else if (cyc >= 20) begin
        checks++;
        failures++;
        $display("FAIL xfer_timeout u%0d addr %h: no PReady within %0d cycles", u, a, cyc);
        psel[u] = 1'b0;
        penable[u] = 1'b0;
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (scramble) begin paddr[u] = 16'($urandom); pwdata[u] = $urandom; end
      end
    end
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel[u] = 1'b0;
      penable[u] = 1'b0;
    end
  endtask

  task automatic rand_run(input int u, input int n);
    logic [31:0] rd, d, rd2;
    logic        err, err2;
    logic [15:0] a;
    logic        wr;
    int          cyc, cyc2;
    for (int k = 0; k < n; k++) begin
      wr = 1'($urandom_range(1, 0));
      a = ($urandom_range(9, 0) == 0) ? 16'($urandom_range(65535, DEPTH)) : 16'($urandom_range(DEPTH - 1, 0));
      d = $urandom;
      xfer(u, wr, a, d, 1'($urandom_range(1, 0)), rd, err, cyc);
      check($sformatf("rnd_cyc u%0d", u), 32'(cyc), 32'(2 + wc(u)));
      check($sformatf("rnd_err u%0d", u), {31'd0, err}, {31'd0, (a >= DEPTH)});
      if (wr && $urandom_range(2, 0) == 0) begin
        xfer(u, 1'b0, a, 32'h0, 1'b0, rd2, err2, cyc2);
        check($sformatf("rnd_raw u%0d", u), rd2, (a < DEPTH) ? d : 32'h0);
      end else if (wr) begin
        check($sformatf("rnd_wr_rdata u%0d", u), rd, 32'h0);
      end
      if ($urandom_range(2, 0) != 0) idle(u, int'($urandom_range(2, 1)));
    end
    idle(u, 1);
  endtask

  initial begin
    logic [31:0] rd, rd0, rd1, ror0, ror1;
    logic        err, e0, e1, eor0, eor1;
    int          c1, c2, c0i, c1i, csum0, csum1;

    Rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0; paddr[u] = '0; pwdata[u] = '0;
      in_xfer[u] = 1'b0; acc_n[u] = 0;
    end
    #1 Rst = 1'b0;
    #100 Rst = 1'b1;
    repeat (2) @(posedge clk);

    // Fill both arrays through the bus so the model knows every word.
    ror0 = '0; ror1 = '0; eor0 = 1'b0; eor1 = 1'b0; csum0 = 0; csum1 = 0;
    fork
      begin
        for (int i = 0; i < DEPTH; i++) begin
          xfer(0, 1'b1, 16'(i), 32'h1000_0000 | i, 1'b0, rd0, e0, c0i);
          ror0 |= rd0; eor0 |= e0; csum0 += c0i;
        end
        idle(0, 1);
      end
      begin
        for (int i = 0; i < DEPTH; i++) begin
          xfer(1, 1'b1, 16'(i), 32'h2000_0000 | i, 1'b0, rd1, e1, c1i);
          ror1 |= rd1; eor1 |= e1; csum1 += c1i;
        end
        idle(1, 1);
      end
    join
    check("init_cycles_w0", 32'(csum0), 32'(DEPTH * 2));
    check("init_cycles_w2", 32'(csum1), 32'(DEPTH * 4));
    check("init_flags", {ror0 | ror1}, 32'h0);
    check("init_err", {30'd0, eor0, eor1}, 32'h0);
    mem_scan(0, "init_scan_w0");
    mem_scan(1, "init_scan_w2");
    check("init_lit_w2", peek(1, 16'h10), 32'h2000_0010);

    // Write then immediate readback, zero wait states.
    xfer(0, 1'b1, 16'h50, 32'h50, 1'b0, rd, err, c1);
    check("w50_cycles", 32'(c1), 32'd2);
    check("w50_err", {31'd0, err}, 32'd0);
    xfer(0, 1'b0, 16'h50, 32'h0, 1'b0, rd, err, c2);
    check("r50_data", rd, 32'h50);
    check("pair_cycles", 32'(c1 + c2), 32'd4);
    check("mem50", peek(0, 16'h50), 32'h50);
    idle(0, 1);

    // Two wait states: array must still hold the old word in the PReady cycle.
    xfer(1, 1'b1, 16'h10, 32'hA5A5_0001, 1'b0, rd, err, c1);
    check("w10_cycles", 32'(c1), 32'd4);
    check("w10_before", peek(1, 16'h10), 32'h2000_0010);
    @(posedge clk); #1;
    check("w10_after", peek(1, 16'h10), 32'hA5A5_0001);
    idle(1, 1);

    // Out-of-range accesses.
    xfer(0, 1'b1, 16'h0100, 32'hDEAD_BEEF, 1'b0, rd, err, c1);
    check("oor_w_err", {31'd0, err}, 32'd1);
    check("oor_w_cycles", 32'(c1), 32'd2);
    idle(0, 1);
    mem_scan(0, "oor_w_nochange");
    xfer(0, 1'b0, 16'h0100, 32'h0, 1'b0, rd, err, c1);
    check("oor_r_data", rd, 32'h0);
    check("oor_r_err", {31'd0, err}, 32'd1);
    xfer(1, 1'b0, 16'hFFFF, 32'h0, 1'b0, rd, err, c1);
    check("oor_ffff_err", {31'd0, err}, 32'd1);
    check("oor_ffff_data", rd, 32'h0);
    idle(0, 1);
    idle(1, 1);

    // PEnable without a setup phase is ignored.
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 16'h50;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_setup_rdy", {31'd0, pready[0]}, 32'd0);
    end
    idle(0, 1);

    // Reset during the PReady cycle (0 waits) and during a wait state (2 waits).
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 16'h50;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 16'h20; pwdata[1] = 32'h1234;
    @(posedge clk); #1;
    penable[0] = 1'b1; penable[1] = 1'b1;
    #1;
    check("pre_rst_rdy0", {31'd0, pready[0]}, 32'd1);
    check("pre_rst_rdata0", prdata[0], 32'h50);
    Rst = 1'b0;
    #1;
    check("rst_rdy0", {31'd0, pready[0]}, 32'd0);
    check("rst_rdata0", prdata[0], 32'h0);
    check("rst_out1", {29'd0, pready[1], pslverr[1], |prdata[1]}, 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    #3 Rst = 1'b1;
    idle(1, 4);
    check("rst_mem20", peek(1, 16'h20), 32'h2000_0020);
    mem_scan(1, "rst_scan_w2");
    xfer(1, 1'b1, 16'h20, 32'h1234, 1'b0, rd, err, c1);
    check("post_rst_cycles", 32'(c1), 32'd4);
    xfer(1, 1'b0, 16'h20, 32'h0, 1'b0, rd, err, c1);
    check("post_rst_read", rd, 32'h1234);
    idle(1, 1);

    // Randomized traffic on both instances at once.
    fork
      rand_run(0, 250);
      rand_run(1, 250);
    join
    idle(0, 1);
    mem_scan(0, "final_scan_w0");
    mem_scan(1, "final_scan_w2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
